// File: rtl/fetch_unit_if.sv
// Bus between the fetch unit and its surroundings: the instruction memory
// port, the redirect/stall controls coming back from decode, and the IF/ID
// register plus status outputs.
//   master : the fetch unit (drives inst_addr, IF/ID fields, status)
//   slave  : memory + decode side (drives instr, stall and redirects)
interface fetch_unit_if;
  logic [31:0] inst_addr;
  logic [31:0] instr;
  logic        stall;
  logic        branch_taken;
  logic [31:0] branch_target;
  logic        jump;
  logic [25:0] jump_index;
  logic        jr;
  logic [31:0] jr_target;
  logic [31:0] if_instr;
  logic [31:0] if_pc;
  logic [31:0] if_pc_plus4;
  logic        if_valid;
  logic        halted;
  logic        misaligned;
  logic [31:0] fetch_count;

  modport master (
    output inst_addr, if_instr, if_pc, if_pc_plus4, if_valid,
           halted, misaligned, fetch_count,
    input  instr, stall, branch_taken, branch_target, jump, jump_index,
           jr, jr_target
  );

  modport slave (
    input  inst_addr, if_instr, if_pc, if_pc_plus4, if_valid,
           halted, misaligned, fetch_count,
    output instr, stall, branch_taken, branch_target, jump, jump_index,
           jr, jr_target
  );
endinterface

// File: rtl/fetch_unit.sv
// Instruction fetch stage with IF/ID register.
// Drives inst_addr (PC, or EOF_ADDR once halted); the memory answers with
// instr in the same cycle and the word is captured into IF/ID on the next
// rising edge. Decode feeds back stall and redirects (jr > jump > branch).
// Ports:
//   clk   - sole clock, rising edge
//   rst_n - synchronous active-low reset, overrides everything
//   bus   - fetch_unit_if.master (memory port, redirects, IF/ID, status)
module fetch_unit #(
  parameter logic [31:0] RESET_PC   = 32'h0000_3000,
  parameter logic [31:0] EOF_ADDR   = 32'hFFFF_FFFF,
  parameter logic [5:0]  HLT_OPCODE = 6'h3F
) (
  input  logic            clk,
  input  logic            rst_n,
  fetch_unit_if.master    bus
);

  typedef enum logic {RUN, HALT} state_t;

  state_t      state;
  logic [31:0] pc;
  logic [31:0] if_instr;
  logic [31:0] if_pc;
  logic [31:0] if_pc_plus4;
  logic        if_valid;
  logic        misaligned;
  logic [31:0] fetch_count;

  logic [31:0] pc_plus4;
  logic        redirect;
  logic [31:0] redirect_target;

  function automatic logic [31:0] word_align(input logic [31:0] addr);
    return {addr[31:2], 2'b00};
  endfunction

  // Redirect selection; jump builds its target from the IF/ID sequential
  // address because the jump instruction itself sits in IF/ID.
  always_comb begin
    pc_plus4        = pc + 32'd4;
    redirect        = bus.jr | bus.jump | bus.branch_taken;
    redirect_target = bus.branch_target;
    if (bus.jr)
      redirect_target = bus.jr_target;
    else if (bus.jump)
      redirect_target = {if_pc_plus4[31:28], bus.jump_index, 2'b00};
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state       <= RUN;
      pc          <= RESET_PC;
      if_instr    <= 32'h0;
      if_pc       <= 32'h0;
      if_pc_plus4 <= 32'h0;
      if_valid    <= 1'b0;
      misaligned  <= 1'b0;
      fetch_count <= 32'h0;
    end else if (!bus.stall) begin
      if (state == HALT) begin
        // The hlt already had its one valid cycle; only bubbles from now on.
        if_valid <= 1'b0;
      end else if (redirect) begin
        // Wrong-path word currently on instr is dropped (even a hlt).
        pc       <= word_align(redirect_target);
        if_valid <= 1'b0;
        if (redirect_target[1:0] != 2'b00)
          misaligned <= 1'b1;
      end else begin
        if_instr    <= bus.instr;
        if_pc       <= pc;
        if_pc_plus4 <= pc_plus4;
        if_valid    <= 1'b1;
        fetch_count <= fetch_count + 32'd1;
        pc          <= pc_plus4;
        if (bus.instr[31:26] == HLT_OPCODE)
          state <= HALT;
      end
    end
  end

  assign bus.inst_addr   = (state == HALT) ? EOF_ADDR : pc;
  assign bus.if_instr    = if_instr;
  assign bus.if_pc       = if_pc;
  assign bus.if_pc_plus4 = if_pc_plus4;
  assign bus.if_valid    = if_valid;
  assign bus.halted      = (state == HALT);
  assign bus.misaligned  = misaligned;
  assign bus.fetch_count = fetch_count;

endmodule

// File: tb/tb_fetch_unit.sv
// Bench for fetch_unit: directed scenarios followed by a randomized run,
// all outputs compared every cycle against a behavioural model.
module tb_fetch_unit;
  localparam logic [31:0] EOF = 32'hFFFF_FFFF;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  fetch_unit_if bus();

  fetch_unit dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  int total = 0;
  int bad   = 0;

  // Instruction memory: a fixed non-hlt pattern, with one optional hlt word.
  logic        hlt_en   = 1'b0;
  logic [31:0] hlt_addr = 32'h0;

  function automatic logic [31:0] mem_word(input logic [31:0] a, input logic en,
                                           input logic [31:0] ha);
    if (en && a == ha) return 32'hFC00_0000;
    return {6'h02, a[27:2]} ^ 32'h0155_AA33;
  endfunction

  always_comb bus.instr = mem_word(bus.inst_addr, hlt_en, hlt_addr);

  // Behavioural model state
  logic        m_halt;
  logic [31:0] m_pc, m_ifi, m_ifpc, m_ifp4, m_cnt;
  logic        m_ifv, m_mis;

  task automatic model_step();
    logic [31:0] tgt, w;
    if (!rst_n) begin
      m_halt = 0; m_pc = 32'h3000; m_ifi = 0; m_ifpc = 0; m_ifp4 = 0;
      m_ifv = 0; m_mis = 0; m_cnt = 0;
    end else if (bus.stall) begin
      // everything holds
    end else if (m_halt) begin
      m_ifv = 0;
    end else if (bus.jr || bus.jump || bus.branch_taken) begin
      if (bus.jr) tgt = bus.jr_target;
      else if (bus.jump) tgt = (m_ifp4 & 32'hF000_0000) + ({6'h0, bus.jump_index} * 4);
      else tgt = bus.branch_target;
      if (tgt % 4 != 0) m_mis = 1;
      m_pc  = tgt - (tgt % 4);
      m_ifv = 0;
    end else begin
      w      = mem_word(m_pc, hlt_en, hlt_addr);
      m_ifi  = w;
      m_ifpc = m_pc;
      m_ifp4 = m_pc + 4;
      m_ifv  = 1;
      m_cnt  = m_cnt + 1;
      m_pc   = m_pc + 4;
      if (w / 32'h0400_0000 == 63) m_halt = 1;
    end
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic check_all();
    chk("inst_addr",   bus.inst_addr,   m_halt ? EOF : m_pc);
    chk("if_instr",    bus.if_instr,    m_ifi);
    chk("if_pc",       bus.if_pc,       m_ifpc);
    chk("if_pc_plus4", bus.if_pc_plus4, m_ifp4);
    chk("if_valid",    {31'h0, bus.if_valid},   {31'h0, m_ifv});
    chk("halted",      {31'h0, bus.halted},     {31'h0, m_halt});
    chk("misaligned",  {31'h0, bus.misaligned}, {31'h0, m_mis});
    chk("fetch_count", bus.fetch_count, m_cnt);
  endtask

  task automatic step(input logic r, input logic s, input logic b,
                      input logic [31:0] bt, input logic j, input logic [25:0] ji,
                      input logic jrr, input logic [31:0] jt);
    rst_n             = r;
    bus.stall         = s;
    bus.branch_taken  = b;
    bus.branch_target = bt;
    bus.jump          = j;
    bus.jump_index    = ji;
    bus.jr            = jrr;
    bus.jr_target     = jt;
    @(posedge clk);
    model_step();
    #1;
    check_all();
  endtask

  task automatic seq();
    step(1, 0, 0, 0, 0, 0, 0, 0);
  endtask

  task automatic rst();
    step(0, 0, 0, 0, 0, 0, 0, 0);
  endtask

  initial begin
    // Reset and sequential fetch
    rst(); rst();
    chk("rst_addr", bus.inst_addr, 32'h3000);
    seq();
    chk("lag_if_pc", bus.if_pc, 32'h3000);
    chk("seq_addr1", bus.inst_addr, 32'h3004);
    seq(); seq();
    chk("seq_count3", bus.fetch_count, 32'd3);

    // Misaligned branch
    step(1, 0, 1, 32'h0000_3102, 0, 0, 0, 0);
    chk("br_addr", bus.inst_addr, 32'h3100);
    chk("br_bubble", {31'h0, bus.if_valid}, 32'h0);
    chk("br_mis", {31'h0, bus.misaligned}, 32'h1);
    seq();
    chk("mis_sticky", {31'h0, bus.misaligned}, 32'h1);

    // jr beats jump beats branch
    step(1, 0, 1, 32'h5000, 1, 26'h0000123, 1, 32'h0000_4000);
    chk("prio_jr", bus.inst_addr, 32'h4000);

    // Jump target built from if_pc_plus4
    step(1, 0, 0, 0, 0, 0, 1, 32'h1000_000C);
    seq();
    chk("jmp_p4", bus.if_pc_plus4, 32'h1000_0010);
    step(1, 0, 0, 0, 1, 26'h0000040, 0, 0);
    chk("jmp_addr", bus.inst_addr, 32'h1000_0100);

    // Stall holds everything and ignores the branch
    for (int i = 0; i < 3; i++) step(1, 1, 1, 32'h7000, 0, 0, 0, 0);
    chk("stall_addr", bus.inst_addr, 32'h1000_0100);
    chk("stall_cnt", bus.fetch_count, 32'd5);
    seq();
    chk("stall_resume", bus.if_pc, 32'h1000_0100);

    // PC wrap without flagging
    rst();
    step(1, 0, 0, 0, 0, 0, 1, 32'hFFFF_FFFC);
    seq();
    chk("wrap_addr", bus.inst_addr, 32'h0);
    chk("wrap_mis", {31'h0, bus.misaligned}, 32'h0);
    chk("wrap_p4", bus.if_pc_plus4, 32'h0);

    // hlt at 300C
    hlt_en = 1'b1; hlt_addr = 32'h0000_300C;
    rst();
    seq(); seq(); seq();
    chk("hlt_fetch_addr", bus.inst_addr, 32'h300C);
    seq();
    chk("hlt_instr", bus.if_instr, 32'hFC00_0000);
    chk("hlt_valid", {31'h0, bus.if_valid}, 32'h1);
    chk("hlt_eof", bus.inst_addr, EOF);
    step(1, 0, 1, 32'h3000, 1, 26'h1, 1, 32'h3000);
    chk("halt_bubble", {31'h0, bus.if_valid}, 32'h0);
    chk("halt_addr", bus.inst_addr, EOF);
    chk("halt_flag", {31'h0, bus.halted}, 32'h1);
    rst();
    chk("halt_rst", bus.inst_addr, 32'h3000);

    // hlt fetched together with a redirect is dropped
    seq(); seq(); seq();
    step(1, 0, 1, 32'h3040, 0, 0, 0, 0);
    chk("hlt_drop", {31'h0, bus.halted}, 32'h0);

    // Randomized run, hlt planted at 3020
    hlt_addr = 32'h0000_3020;
    rst();
    for (int i = 0; i < 600; i++) begin
      logic r, s;
      int   rd;
      r  = ($urandom_range(0, 39) != 0);
      s  = ($urandom_range(0, 3) == 0);
      rd = $urandom_range(0, 9);
      step(r, s,
           (rd == 1 || rd == 4), 32'h3000 + $urandom_range(0, 127),
           (rd == 2 || rd == 4), 26'h0000C00 + 26'($urandom_range(0, 31)),
           (rd == 3 || rd == 4), $urandom);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/fetch_unit.md
FETCH_UNIT -- requirements
Module: fetch_unit

Interface
REQ-001 SHALL have parameter RESET_PC, default 32'h0000_3000, meaning address of the first fetched instruction.
REQ-002 SHALL have parameter EOF_ADDR, default 32'hFFFF_FFFF, meaning inst_addr value driven once halted.
REQ-003 SHALL have parameter HLT_OPCODE, default 6'h3F, meaning instr[31:26] value that encodes hlt.
REQ-004 clk  input  1  sole clock; all state updates on rising edge.
REQ-005 rst_n  input  1  synchronous, active-low reset.
REQ-006 inst_addr  output  32  instruction memory address; memory returns instr combinationally in the same cycle.
REQ-007 instr  input  32  instruction word at inst_addr.
REQ-008 stall  input  1  freezes PC and IF/ID register.
REQ-009 branch_taken  input  1  redirect to branch_target.
REQ-010 branch_target  input  32  branch destination.
REQ-011 jump  input  1  redirect to {if_pc_plus4[31:28], jump_index, 2'b00}.
REQ-012 jump_index  input  26  J-format target field.
REQ-013 jr  input  1  redirect to jr_target.
REQ-014 jr_target  input  32  register-indirect destination.
REQ-015 if_instr  output  32  IF/ID instruction register.
REQ-016 if_pc  output  32  address of if_instr.
REQ-017 if_pc_plus4  output  32  if_pc + 4, mod 2^32.
REQ-018 if_valid  output  1  if_instr holds a real instruction.
REQ-019 halted  output  1  hlt retired; fetch stopped.
REQ-020 misaligned  output  1  sticky flag: a redirect target had nonzero bits [1:0].
REQ-021 fetch_count  output  32  instructions accepted into IF/ID since reset.

Function
REQ-022 SHALL implement states RUN and HALT; inst_addr = PC in RUN, EOF_ADDR in HALT.
REQ-023 Next-PC priority in RUN SHALL be: stall (hold) > jr > jump > branch_taken > PC+4.
REQ-024 Redirect targets SHALL be forced word-aligned (bits [1:0] cleared); misaligned sets to 1 and holds until reset.
REQ-025 PC+4 SHALL wrap 32'hFFFF_FFFC -> 32'h0000_0000 without flagging.
REQ-026 Redirects come from decode of the IF/ID instruction; when any redirect is applied (no stall), IF/ID SHALL load a bubble (if_valid=0) on that edge, discarding the wrong-path instr.
REQ-027 With no stall and no redirect in RUN, IF/ID SHALL load {instr, PC, PC+4}, if_valid=1, and fetch_count increments by 1 (wrapping).
REQ-028 With stall=1, PC, IF/ID, fetch_count and state SHALL hold; redirect inputs ignored that cycle.
REQ-029 When an instruction with opcode HLT_OPCODE is accepted into IF/ID, state SHALL become HALT on the same edge; hlt is presented with if_valid=1 for exactly one (non-stalled) cycle.
REQ-030 A hlt fetched in the same cycle as a redirect SHALL be discarded (redirect wins); no halt.
REQ-031 In HALT: halted=1, inst_addr=EOF_ADDR, if_valid=0 from the next edge when not stalled, PC and fetch_count frozen, all redirect inputs ignored; exit only via reset.
REQ-032 Latency: an instruction at address A appears on if_instr one edge after inst_addr=A with stall=0.

Reset
REQ-033 While rst_n=0 at a rising edge: state=RUN, PC=RESET_PC, if_instr=32'h0, if_pc=32'h0, if_pc_plus4=32'h0, if_valid=0, halted=0, misaligned=0, fetch_count=0.
REQ-034 Reset SHALL override stall, redirects and HALT; reset asserted mid-redirect or in HALT returns to REQ-033 values on that edge.

Verification
REQ-035 Reset release, sequential non-hlt instrs, no stall -> inst_addr 3000, 3004, 3008; if_pc lags by one cycle; fetch_count=3 after 3 edges.
REQ-036 branch_taken=1, branch_target=32'h0000_3102 -> next inst_addr 32'h0000_3100, if_valid=0 one cycle, misaligned=1 sticky.
REQ-037 jr and jump and branch all asserted, jr_target=32'h0000_4000 -> inst_addr 32'h0000_4000; jump with if_pc_plus4=32'h1000_0010, jump_index=26'h0000040 -> 32'h1000_0100.
REQ-038 stall=1 for 3 cycles with branch_taken=1 -> PC, if_instr, fetch_count unchanged; on release sequential fetch resumes.
REQ-039 hlt (32'hFC00_0000) fetched at 32'h0000_300C -> one cycle if_valid=1 with hlt, then halted=1, inst_addr=32'hFFFF_FFFF held; later redirects ignored; rst_n=0 -> inst_addr 32'h0000_3000.
REQ-040 PC preset near top via jr_target=32'hFFFF_FFFC -> next sequential inst_addr 32'h0000_0000, misaligned stays 0.
